// File: rtl/adc_seq_manager_if.sv
// Bundled signal set of adc_seq_manager: trigger, SPI pins, command/result/readback streams, status.
// The slave modport is the sequencer's view; master is the environment driving it.
interface adc_seq_manager_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SDI    = 4
);
  logic                  trigger;
  logic [NUM_SDI-1:0]    spi_sdi;
  logic                  spi_sdo;
  logic                  spi_csn;
  logic                  spi_clk;
  logic [31:0]           s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [7:0]            m_reg_tdata;
  logic                  m_reg_tvalid;
  logic                  m_reg_tready;
  logic [31:0]           status;
  logic                  ready;

  modport slave (
    input  trigger, spi_sdi, s_axis_tdata, s_axis_tvalid, m_axis_tready, m_reg_tready,
    output spi_sdo, spi_csn, spi_clk, s_axis_tready, m_axis_tdata, m_axis_tvalid,
           m_reg_tdata, m_reg_tvalid, status, ready
  );

  modport master (
    output trigger, spi_sdi, s_axis_tdata, s_axis_tvalid, m_axis_tready, m_reg_tready,
    input  spi_sdo, spi_csn, spi_clk, s_axis_tready, m_axis_tdata, m_axis_tvalid,
           m_reg_tdata, m_reg_tvalid, status, ready
  );
endinterface

// File: rtl/adc_seq_manager.sv
// SPI ADC sequencer: runs conversions on trigger and 24-bit register accesses from a command stream.
// Optional macro ADC_READBACK_EN adds lane-0 register readback on m_reg_*.
module adc_seq_manager #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SDI    = 4,
  parameter int SCLK_HALF  = 1,
  parameter int CS_HOLD    = 2
) (
  input logic              aclk,
  input logic              areset,
  adc_seq_manager_if.slave bus
);
  localparam int CONV_BITS = DATA_WIDTH / NUM_SDI;
  localparam int MAX_BITS  = (CONV_BITS > 24) ? CONV_BITS : 24;
  localparam int BW        = $clog2(MAX_BITS + 1);
  localparam int CW        = $clog2(((SCLK_HALF > CS_HOLD) ? SCLK_HALF : CS_HOLD) + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, HOLD = 2'd3} state_t;
  typedef enum logic [1:0] {MODE_CONV = 2'b00, MODE_REG_ONCE = 2'b01, MODE_REG = 2'b11} mode_t;

  state_t                state_q;
  mode_t                 mode_q;
  logic [23:0]           cmd_q;
  logic [23:0]           sdo_sh_q;
  logic                  reg_pending_q;
  logic                  is_reg_q;
  logic                  high_q;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic                  csn_q;
  logic                  sclk_q;
  logic                  sdo_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] data_sh_q;
  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic                  m_tvalid_q;
  logic                  overflow_q;
  logic [7:0]            missed_q;

  logic                  sample_s;
  logic                  last_s;
  logic [BW-1:0]         last_bit_s;
  logic                  reg_valid_s;
  logic [DATA_WIDTH-1:0] conv_word_s;

  assign last_bit_s  = is_reg_q ? BW'(23) : BW'(CONV_BITS - 1);
  assign sample_s    = (state_q == SHIFT) && high_q && (cnt_q == CW'(SCLK_HALF - 1));
  assign last_s      = sample_s && (bit_cnt_q == last_bit_s);
  assign conv_word_s = {data_sh_q[DATA_WIDTH-NUM_SDI-1:0], bus.spi_sdi};

  // Sequencer FSM with all SPI pins, stream handshakes, mode and status counters registered
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= IDLE;
      mode_q        <= MODE_CONV;
      cmd_q         <= 24'h000000;
      sdo_sh_q      <= 24'h000000;
      reg_pending_q <= 1'b0;
      is_reg_q      <= 1'b0;
      high_q        <= 1'b0;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      csn_q         <= 1'b1;
      sclk_q        <= 1'b0;
      sdo_q         <= 1'b0;
      ready_q       <= 1'b0;
      data_sh_q     <= '0;
      m_tdata_q     <= '0;
      m_tvalid_q    <= 1'b0;
      overflow_q    <= 1'b0;
      missed_q      <= 8'h00;
    end else begin
      if (m_tvalid_q && bus.m_axis_tready) m_tvalid_q <= 1'b0;
      if (bus.trigger && (state_q != IDLE) && (mode_q == MODE_CONV) && (missed_q != 8'hFF))
        missed_q <= missed_q + 8'd1;

      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          bit_cnt_q <= '0;
          high_q    <= 1'b0;
          data_sh_q <= '0;
          if (ready_q && bus.s_axis_tvalid) begin
            cmd_q         <= bus.s_axis_tdata[23:0];
            reg_pending_q <= 1'b1;
            ready_q       <= 1'b0;
            if (mode_q != MODE_REG) mode_q <= MODE_REG_ONCE;
          end else if (reg_pending_q) begin
            // Register access: first command bit is on sdo from the moment csn drops
            state_q       <= SETUP;
            csn_q         <= 1'b0;
            sdo_q         <= cmd_q[23];
            sdo_sh_q      <= {cmd_q[22:0], 1'b0};
            is_reg_q      <= 1'b1;
            reg_pending_q <= 1'b0;
            ready_q       <= 1'b0;
          end else if (bus.trigger && (mode_q == MODE_CONV)) begin
            state_q  <= SETUP;
            csn_q    <= 1'b0;
            sdo_q    <= 1'b0;
            sdo_sh_q <= 24'h000000;
            is_reg_q <= 1'b0;
            ready_q  <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_q == CW'(SCLK_HALF - 1)) begin
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SHIFT: begin
          if (cnt_q != CW'(SCLK_HALF - 1)) begin
            cnt_q <= cnt_q + CW'(1);
          end else if (!high_q) begin
            cnt_q  <= '0;
            high_q <= 1'b1;
            sclk_q <= 1'b1;
          end else begin
            cnt_q     <= '0;
            high_q    <= 1'b0;
            sclk_q    <= 1'b0;
            data_sh_q <= conv_word_s;
            if (last_s) begin
              csn_q   <= 1'b1;
              sdo_q   <= 1'b0;
              state_q <= HOLD;
              if (is_reg_q) begin
                if (cmd_q[23:21] == 3'b101) begin
                  mode_q <= MODE_REG;
                end else if ((cmd_q == 24'h001401) || (mode_q == MODE_REG_ONCE)) begin
                  mode_q <= MODE_CONV;
                end else begin
                  mode_q <= mode_q;
                end
              end else begin
                m_tdata_q  <= conv_word_s;
                m_tvalid_q <= 1'b1;
                if (m_tvalid_q && !bus.m_axis_tready) overflow_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
              sdo_q     <= sdo_sh_q[23];
              sdo_sh_q  <= {sdo_sh_q[22:0], 1'b0};
            end
          end
        end
        HOLD: begin
          if (cnt_q == CW'(CS_HOLD - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          csn_q   <= 1'b1;
          sclk_q  <= 1'b0;
          sdo_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef ADC_READBACK_EN
  logic [7:0] rb_sh_q;
  logic [7:0] rb_data_q;
  logic       rb_valid_q;

  // Lane-0 capture during register accesses; a newer readback overwrites an unread one
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rb_sh_q    <= 8'h00;
      rb_data_q  <= 8'h00;
      rb_valid_q <= 1'b0;
    end else begin
      if (rb_valid_q && bus.m_reg_tready) rb_valid_q <= 1'b0;
      if (sample_s && is_reg_q) begin
        rb_sh_q <= {rb_sh_q[6:0], bus.spi_sdi[0]};
        if (last_s) begin
          rb_data_q  <= {rb_sh_q[6:0], bus.spi_sdi[0]};
          rb_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.m_reg_tdata  = rb_data_q;
  assign reg_valid_s      = rb_valid_q;
`else
  assign bus.m_reg_tdata  = 8'h00;
  assign reg_valid_s      = 1'b0;
`endif

  assign bus.m_reg_tvalid  = reg_valid_s;
  assign bus.spi_csn       = csn_q;
  assign bus.spi_clk       = sclk_q;
  assign bus.spi_sdo       = sdo_q;
  assign bus.ready         = ready_q;
  assign bus.s_axis_tready = ready_q;
  assign bus.m_axis_tdata  = m_tdata_q;
  assign bus.m_axis_tvalid = m_tvalid_q;
  assign bus.status        = {16'h0000, missed_q, 1'b0, reg_valid_s, overflow_q, m_tvalid_q,
                              mode_q, reg_pending_q, (state_q != IDLE)};
endmodule

// File: tb/tb_adc_seq_manager.sv
// Self-checking bench for adc_seq_manager: behavioural ADC on the SPI pins plus a result scoreboard.
`timescale 1ns/1ps
module tb_adc_seq_manager;
  localparam int DW = 32;
  localparam int NS = 4;

  logic aclk = 1'b0;
  logic areset = 1'b1;

  adc_seq_manager_if #(.DATA_WIDTH(DW), .NUM_SDI(NS)) bus ();

  adc_seq_manager #(.DATA_WIDTH(DW), .NUM_SDI(NS), .SCLK_HALF(1), .CS_HOLD(2)) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  // ADC model: one sdi group per SPI bit, advancing on each spi_clk fall
  logic [NS-1:0] adc_groups [0:31];
  logic [4:0]    fall_cnt = 5'd0;
  logic [23:0]   sdo_cap = 24'h0;
  int            clk_pulses = 0;

  assign bus.spi_sdi = adc_groups[fall_cnt];

  always @(negedge bus.spi_clk or posedge bus.spi_csn) begin
    if (bus.spi_csn) fall_cnt = 5'd0;
    else fall_cnt = fall_cnt + 5'd1;
  end

  always @(posedge bus.spi_clk or negedge bus.spi_csn) begin
    if (!bus.spi_clk) begin
      sdo_cap    = 24'h0;
      clk_pulses = 0;
    end else begin
      sdo_cap    = {sdo_cap[22:0], bus.spi_sdo};
      clk_pulses = clk_pulses + 1;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic load_conv(input logic [DW-1:0] word);
    for (int k = 0; k < 32; k++) adc_groups[k] = '0;
    for (int k = 0; k < DW / NS; k++) adc_groups[k] = word[DW-1-NS*k -: NS];
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(bus.ready === 1'b1 && bus.status[0] === 1'b0) && n < 600) begin
      tick();
      n++;
    end
    if (n >= 600) begin
      checks++; errors++;
      $display("FAIL %s_timeout: ready=%b status=%h, want ready=1 and idle", tag, bus.ready, bus.status);
    end
  endtask

  task automatic pulse_trigger();
    wait_idle("trig_ready");
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
  endtask

  task automatic expect_output(input string tag);
    int n = 0;
    logic [DW-1:0] exp;
    while (bus.m_axis_tvalid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_out: tvalid=%b queued=%0d, want a beat for a queued word", tag, bus.m_axis_tvalid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      if (bus.m_axis_tdata !== exp) begin
        errors++;
        $display("FAIL %s_data: got %h expected %h", tag, bus.m_axis_tdata, exp);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({bus.spi_csn, bus.spi_clk, bus.spi_sdo, bus.s_axis_tready, bus.m_axis_tvalid, bus.m_reg_tvalid} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_pins: csn/clk/sdo/tready/tvalid/regvalid=%b expected 100000",
               {bus.spi_csn, bus.spi_clk, bus.spi_sdo, bus.s_axis_tready, bus.m_axis_tvalid, bus.m_reg_tvalid});
    end
    checks++;
    if (bus.status !== 32'h0) begin
      errors++; $display("FAIL reset_status: got %h expected 00000000", bus.status);
    end
    areset = 1'b0;
    tick(); tick();
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready);
    end
  endtask

  task automatic test_conversion();
    wait_idle("conv_ready");
    load_conv(32'h12345678);
    bus.m_axis_tready = 1'b0;
    exp_q.push_back(32'h12345678);
    bus.trigger = 1'b1;                     // cycle 0
    for (int c = 1; c <= 20; c++) begin
      tick();
      bus.trigger = 1'b0;
      checks++;
      if (bus.spi_csn !== ((c <= 17) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL conv_csn_c%0d: got %b expected %b", c, bus.spi_csn, (c <= 17) ? 1'b0 : 1'b1);
      end
      if (c == 17) begin
        checks++;
        if (bus.m_axis_tvalid !== 1'b0) begin
          errors++; $display("FAIL conv_tvalid_early: got %b expected 0", bus.m_axis_tvalid);
        end
      end
      if (c == 18) begin
        expect_output("conv");
        checks++;
        if (clk_pulses != 8) begin
          errors++; $display("FAIL conv_pulses: got %0d expected 8", clk_pulses);
        end
      end
      if (c == 19 || c == 20) begin
        checks++;
        if (bus.ready !== ((c == 20) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL conv_ready_c%0d: got %b expected %b", c, bus.ready, (c == 20) ? 1'b1 : 1'b0);
        end
      end
    end
    checks++;
    if (bus.status[15:4] !== 12'h001) begin
      errors++; $display("FAIL conv_status: got %h expected missed=00 tvalid=1 ovf=0", bus.status[15:4]);
    end
    bus.m_axis_tready = 1'b1;
    tick();
    checks++;
    if (bus.m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL conv_accept: tvalid got %b expected 0", bus.m_axis_tvalid);
    end
  endtask

  task automatic send_cmd(input logic [23:0] cmd, input logic [1:0] mode_now, input logic [1:0] mode_end);
    wait_idle("cmd_ready");
    bus.s_axis_tdata  = {8'hEE, cmd};
    bus.s_axis_tvalid = 1'b1;
    tick();
    bus.s_axis_tvalid = 1'b0;
    checks++;
    if (bus.status[3:1] !== {mode_now, 1'b1}) begin
      errors++; $display("FAIL cmd_%h_accept: mode/pending got %b expected %b", cmd, bus.status[3:1], {mode_now, 1'b1});
    end
    tick();
    checks++;
    if ({bus.spi_csn, bus.spi_sdo} !== {1'b0, cmd[23]}) begin
      errors++; $display("FAIL cmd_%h_start: csn/sdo got %b expected %b", cmd, {bus.spi_csn, bus.spi_sdo}, {1'b0, cmd[23]});
    end
    wait_idle("cmd_done");
    checks++;
    if (sdo_cap !== cmd || clk_pulses != 24) begin
      errors++; $display("FAIL cmd_%h_sdo: got %h/%0d pulses expected %h/24", cmd, sdo_cap, clk_pulses, cmd);
    end
    checks++;
    if ({bus.status[3:2], bus.spi_sdo} !== {mode_end, 1'b0}) begin
      errors++; $display("FAIL cmd_%h_end: mode/sdo got %b expected %b", cmd, {bus.status[3:2], bus.spi_sdo}, {mode_end, 1'b0});
    end
  endtask

  task automatic test_register();
    logic [7:0] rb;
    rb = 8'hA5;
    for (int k = 0; k < 32; k++) adc_groups[k] = '0;
    for (int j = 0; j < 8; j++) adc_groups[16 + j] = {{(NS-1){1'b0}}, rb[7 - j]};
    bus.m_reg_tready = 1'b0;
    send_cmd(24'h001401, 2'b01, 2'b00);
`ifdef ADC_READBACK_EN
    checks++;
    if ({bus.m_reg_tvalid, bus.m_reg_tdata, bus.status[6]} !== {1'b1, 8'hA5, 1'b1}) begin
      errors++; $display("FAIL readback: valid/data/st6 got %b/%h/%b expected 1/a5/1", bus.m_reg_tvalid, bus.m_reg_tdata, bus.status[6]);
    end
    bus.m_reg_tready = 1'b1;
    tick();
    bus.m_reg_tready = 1'b0;
    checks++;
    if (bus.m_reg_tvalid !== 1'b0) begin
      errors++; $display("FAIL readback_accept: got %b expected 0", bus.m_reg_tvalid);
    end
`else
    checks++;
    if ({bus.m_reg_tvalid, bus.m_reg_tdata, bus.status[6]} !== 10'b0) begin
      errors++; $display("FAIL readback_off: valid/data/st6 got %b/%h/%b expected 0/00/0", bus.m_reg_tvalid, bus.m_reg_tdata, bus.status[6]);
    end
`endif
    send_cmd(24'hA00000, 2'b01, 2'b11);
    pulse_trigger();
    repeat (4) tick();
    checks++;
    if ({bus.status[0], bus.m_axis_tvalid} !== 2'b00) begin
      errors++; $display("FAIL reg_mode_trigger: busy/tvalid got %b expected 00", {bus.status[0], bus.m_axis_tvalid});
    end
    send_cmd(24'h001401, 2'b11, 2'b00);
  endtask

  task automatic test_overflow();
    bus.m_axis_tready = 1'b0;
    load_conv(32'hCAFEF00D);
    exp_q.push_back(32'hCAFEF00D);
    pulse_trigger();
    expect_output("ovf_first");
    load_conv(32'h0BADBEEF);
    exp_q.push_back(32'h0BADBEEF);
    pulse_trigger();
    wait_idle("ovf_second");
    expect_output("ovf_second");
    checks++;
    if (bus.status[5:4] !== 2'b11) begin
      errors++; $display("FAIL ovf_flag: status[5:4] got %b expected 11", bus.status[5:4]);
    end
    bus.m_axis_tready = 1'b1;
    tick();
  endtask

  task automatic test_missed();
    bus.m_axis_tready = 1'b1;
    load_conv(32'h13579BDF);
    wait_idle("miss_ready");
    bus.trigger = 1'b1;                     // cycle 0, held through the conversion
    repeat (20) tick();
    bus.trigger = 1'b0;
    checks++;
    if (bus.status[15:8] !== 8'd19) begin
      errors++; $display("FAIL missed_count: got %0d expected 19", bus.status[15:8]);
    end
    bus.trigger = 1'b1;
    repeat (300) tick();
    bus.trigger = 1'b0;
    wait_idle("miss_sat");
    checks++;
    if (bus.status[15:8] !== 8'hFF) begin
      errors++; $display("FAIL missed_saturate: got %h expected ff", bus.status[15:8]);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    bus.m_axis_tready = 1'b1;
    load_conv(32'hDEADBEEF);
    pulse_trigger();                        // now in cycle 1
    repeat (9) tick();                      // cycle 10: bit 4 low phase
    checks++;
    if (bus.spi_csn !== 1'b0 || clk_pulses != 4) begin
      errors++; $display("FAIL mid_position: csn=%b pulses=%0d expected 0/4", bus.spi_csn, clk_pulses);
    end
    areset = 1'b1;
    #1;
    checks++;
    if ({bus.spi_csn, bus.spi_clk, bus.m_axis_tvalid} !== 3'b100 || bus.status !== 32'h0) begin
      errors++; $display("FAIL mid_abort: csn/clk/tvalid=%b status=%h expected 100/00000000",
                         {bus.spi_csn, bus.spi_clk, bus.m_axis_tvalid}, bus.status);
    end
    tick(); tick();
    areset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.m_axis_tvalid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL mid_no_beat: tvalid seen=1 expected 0");
    end
    load_conv(32'h9ABCDEF0);
    exp_q.push_back(32'h9ABCDEF0);
    pulse_trigger();
    expect_output("mid_fresh");
  endtask

  initial begin
    bus.trigger       = 1'b0;
    bus.s_axis_tdata  = 32'h0;
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b0;
    bus.m_reg_tready  = 1'b0;
    for (int k = 0; k < 32; k++) adc_groups[k] = '0;
    test_reset();
    test_conversion();
    test_register();
    test_overflow();
    test_missed();
    test_reset_mid();
    wait_idle("final");
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty: %0d words left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
